// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_ctrl (+ full_adder)
//  Purpose  : Bit-serial a+b+cin, LSB first, one bit per cycle (IDLE/RUN/DONE).
//             Optional signed overflow flag enabled by SERIAL_ADDER_OVF_EN.
//  Revision : 1.0
// ============================================================================

module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             out_ready,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int              CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;
    logic             w_s;
    logic             w_co;
    logic             w_last;
    logic             w_accept;

    // Operand shift registers present their LSB to the single adder cell.
    full_adder u_fa (
        .A    (r_a[0]),
        .B    (r_b[0]),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_co)
    );

    assign w_last   = (r_cnt == c_LAST);
    assign w_accept = (r_state == S_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)     w_next = S_RUN;
            S_RUN:   if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    // sum was cleared at acceptance, so OR-ing places bit r_cnt.
                    r_sum   <= r_sum | (WIDTH'(w_s) << r_cnt);
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_cout <= w_co;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // On the last RUN edge r_carry is the carry into the MSB and w_co the carry out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_ovf <= r_carry ^ w_co;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder_ctrl
//  Purpose  : Self-checking bench: spec vectors table, corner sequences,
//             random operands against an arithmetic reference model.
//  Revision : 1.0
// ============================================================================
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_ready = 1'b0;
    logic         busy;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_ready (out_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;    // overflow expected when the flag is enabled
        int           hold;
    } vec_t;

    vec_t tbl[8];

    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ovf_en(input logic v);
`ifdef SERIAL_ADDER_OVF_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    // Reference: plain integer addition, signed overflow from operand/result signs.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
        logic [W:0] full;
        full   = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        e_sum  = full[W-1:0];
        e_cout = full[W];
        e_ovf  = ovf_en((ma[W-1] == mb[W-1]) && (full[W-1] != ma[W-1]));
    endtask

    // Entered and left at a negedge; leaves the DUT in DONE with result checked.
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic [W-1:0] xs, input logic xc, input logic xo);
        int n;
        e_sum = xs; e_cout = xc; e_ovf = xo;
        a = ta; b = tb; cin = tc; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_valid", out_valid, 0);
        check("accept_sum_clear", sum, 0);
        n = 0;
        while (!out_valid && n < 4 * W + 4) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); start = 1'($urandom);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("latency", n, W);
        check("sum", sum, e_sum);
        check("cout", cout, e_cout);
        check("ovf", ovf, e_ovf);
    endtask

    task automatic hold_done(input int k);
        for (int i = 0; i < k; i++) begin
            start = 1'($urandom); a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_sum", sum, e_sum);
            check("hold_cout", cout, e_cout);
        end
        start = 1'b0;
    endtask

    task automatic release_done();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
        check("idle_sum_kept", sum, e_sum);
        check("idle_ovf_kept", ovf, e_ovf);
    endtask

    initial begin
        tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0};
        tbl[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0};
        tbl[2] = '{8'h3C, 8'hA5, 1'b1, 8'hE2, 1'b0, 1'b0, 5};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1};
        tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0};
        tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 2};
        tbl[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0, 0};
        tbl[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1, 3};

        // Reset held two cycles
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);

        // Reset wins over start
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_prio_busy", busy, 0);

        foreach (tbl[i]) begin
            launch(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, ovf_en(tbl[i].ov));
            hold_done(tbl[i].hold);
            release_done();
        end

        // Reset during RUN of FF+FF, then a clean 01+02
        a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        check("midrst_ovf", ovf, 0);
        launch(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
        release_done();

        // out_ready and start together in DONE: release only, then accept next cycle
        launch(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        out_ready = 1'b1; start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; start = 1'b0;
        check("b2b_busy", busy, 0);
        check("b2b_valid", out_valid, 0);
        check("b2b_sum_kept", sum, 8'h46);
        launch(8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0);
        release_done();

        // Random operands against the reference model
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            model(ra, rb, rc);
            launch(ra, rb, rc, e_sum, e_cout, e_ovf);
            hold_done(int'($urandom_range(0, 3)));
            release_done();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
